// File: rtl/fb_scanout_reader.sv
// Framebuffer scanout reader: raster-order reads into a 2-entry skid buffer,
// streamed out with line/frame markers and optional clear-after-read.
module fb_scanout_reader #(
  parameter int FB_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH    = 4,
  parameter int FB_WIDTH      = 320,
  parameter int FB_HEIGHT     = 240,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear_en,
  output logic                     busy,
  output logic                     done,
  output logic                     fb_read_enable,
  output logic [FB_ADDR_WIDTH-1:0] fb_read_addr,
  input  logic [DATA_WIDTH-1:0]    fb_read_data,
  output logic                     fb_clear_write_enable,
  output logic [FB_ADDR_WIDTH-1:0] fb_clear_addr,
  output logic [DATA_WIDTH-1:0]    fb_clear_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last_x,
  output logic                     out_last
);

  localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR =
    FB_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
  localparam logic [XW-1:0] X_MAX = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  lx;
    logic                  last;
  } ent_t;

  state_t state_q, state_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic clr_q, clr_d;
  logic rd_en_q, rd_en_d;
  logic [FB_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic rd_lx_q, rd_lx_d;
  logic rd_last_q, rd_last_d;
  logic inf_en_q, inf_en_d;
  logic [FB_ADDR_WIDTH-1:0] inf_addr_q, inf_addr_d;
  logic inf_lx_q, inf_lx_d;
  logic inf_last_q, inf_last_d;
  logic [FB_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  ent_t fifo_q [2];
  ent_t fifo_d [2];
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  ent_t arr, head;
  logic valid, pop, store, fifo_pop, credit, issue;
  logic x_last, y_last;
  logic [2:0] outstanding;

  // Output head: buffered word first, else bypass the word arriving now.
  always_comb begin
    arr = '{data: fb_read_data, lx: inf_lx_q, last: inf_last_q};
    head = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : arr;
    valid = (count_q != 2'd0) || inf_en_q;
    pop = valid && out_ready;
    outstanding = {1'b0, count_q} + {2'b0, inf_en_q} + {2'b0, rd_en_q};
    credit = (outstanding - {2'b0, pop}) < 3'd2;
    x_last = (x_q == X_MAX);
    y_last = (y_q == Y_MAX);
  end

  // Next-state logic for FSM, read pipeline, counters and skid buffer.
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    clr_d = clr_q;
    rd_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_lx_d = rd_lx_q;
    rd_last_d = rd_last_q;
    inf_en_d = rd_en_q;
    inf_addr_d = rd_addr_q;
    inf_lx_d = rd_lx_q;
    inf_last_d = rd_last_q;
    cnt_d = cnt_q;
    x_d = x_q;
    y_d = y_q;
    fifo_d = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    fifo_pop = pop && (count_q != 2'd0);
    store = inf_en_q && !((count_q == 2'd0) && pop);
    if (fifo_pop) rd_ptr_d = ~rd_ptr_q;
    if (store) begin
      fifo_d[wr_ptr_q] = arr;
      wr_ptr_d = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, store} - {1'b0, fifo_pop};

    issue = ((state_q == S_IDLE) && start) ||
            ((state_q == S_READ) && credit);
    if (issue) begin
      rd_en_d = 1'b1;
      rd_addr_d = cnt_q;
      rd_lx_d = x_last;
      rd_last_d = x_last && y_last;
      cnt_d = cnt_q + 1'b1;
      if (x_last) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_d = clear_en;
          busy_d = 1'b1;
          state_d = (cnt_q == LAST_ADDR) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (issue && (cnt_q == LAST_ADDR)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          state_d = S_DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        clr_d = 1'b0;
        cnt_d = '0;
        x_d = '0;
        y_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      rd_lx_q <= 1'b0;
      rd_last_q <= 1'b0;
      inf_en_q <= 1'b0;
      inf_addr_q <= '0;
      inf_lx_q <= 1'b0;
      inf_last_q <= 1'b0;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      clr_q <= clr_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_lx_q <= rd_lx_d;
      rd_last_q <= rd_last_d;
      inf_en_q <= inf_en_d;
      inf_addr_q <= inf_addr_d;
      inf_lx_q <= inf_lx_d;
      inf_last_q <= inf_last_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      fifo_q <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fb_read_enable = rd_en_q;
  assign fb_read_addr = rd_addr_q;
  assign fb_clear_write_enable = inf_en_q && clr_q;
  assign fb_clear_addr = inf_addr_q;
  assign fb_clear_data = CLEAR_VALUE;
  assign out_valid = valid;
  assign out_data = valid ? head.data : '0;
  assign out_last_x = valid ? head.lx : 1'b0;
  assign out_last = valid ? head.last : 1'b0;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Scoreboard bench for fb_scanout_reader on a 4x3 frame.
// Expected pixel stream and clear writes come from a frame-level model.
module tb_fb_scanout_reader;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam logic [DW-1:0] CLR = 4'h5;

  logic clk = 1'b0;
  logic rst_n, start, clear_en, busy, done;
  logic fb_read_enable, fb_clear_write_enable;
  logic [AW-1:0] fb_read_addr, fb_clear_addr;
  logic [DW-1:0] fb_read_data, fb_clear_data, out_data;
  logic out_valid, out_ready, out_last_x, out_last;

  fb_scanout_reader #(
    .FB_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_VALUE(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en),
    .busy(busy), .done(done),
    .fb_read_enable(fb_read_enable), .fb_read_addr(fb_read_addr),
    .fb_read_data(fb_read_data),
    .fb_clear_write_enable(fb_clear_write_enable),
    .fb_clear_addr(fb_clear_addr), .fb_clear_data(fb_clear_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last_x(out_last_x), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] ref_mem [N];
  logic [DW+1:0] exp_q [$];
  int clr_q [$];

  // Framebuffer model: synchronous read, clear-write port.
  always @(posedge clk) begin
    if (fb_read_enable) fb_read_data <= mem[fb_read_addr];
    if (fb_clear_write_enable) mem[fb_clear_addr] <= fb_clear_data;
  end

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops, credit bound, clear writes, stall stability.
  int iss = 0;
  int pops = 0;
  bit stall = 0;
  logic [DW+1:0] held;
  always @(negedge clk) begin
    logic [DW+1:0] act, e;
    int ea;
    act = {out_data, out_last_x, out_last};
    if (!rst_n) begin
      iss = 0;
      pops = 0;
      stall = 0;
    end else begin
      if (stall)
        chk(out_valid && act == held, "hold", {31'b0, out_valid} << 8 | act, held);
      if (fb_read_enable) begin
        iss++;
        chk(iss - pops <= 2, "credit", iss - pops, 2);
      end
      if (fb_clear_write_enable) begin
        if (clr_q.size() == 0) begin
          chk(0, "clr_extra", fb_clear_addr, 0);
        end else begin
          ea = clr_q.pop_front();
          chk(fb_clear_addr == AW'(ea) && fb_clear_data == CLR, "clr",
              {fb_clear_data, fb_clear_addr}, {CLR, AW'(ea)});
        end
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk(0, "pix_extra", act, 0);
        end else begin
          e = exp_q.pop_front();
          chk(act == e, "pix", act, e);
        end
      end
      stall = out_valid && !out_ready;
      held = act;
    end
  end

  // One frame. rmode: 0 ready high, 1 random, 2 low for first 20 cycles.
  task automatic run_frame(input bit clr, input int rmode,
                           input bit extra, input int rst_at);
    int first_v = -1;
    int done_k = -1;
    int dones = 0;
    int rd_seen = 0;
    logic [AW-1:0] rd_a [2];
    bit aborted = 0;
    for (int a = 0; a < N; a++) begin
      exp_q.push_back({ref_mem[a], a % W == W - 1, a == N - 1});
      if (clr) clr_q.push_back(a);
    end
    if (clr) for (int a = 0; a < N; a++) ref_mem[a] = CLR;
    for (int k = 0; k < N * 10 + 60; k++) begin
      @(posedge clk);
      #1;
      start = (k == 0) || (extra && (k == 5 || k == 10));
      clear_en = (k == 0) ? clr : 1'($urandom);
      rst_n = !(rst_at > 0 && k == rst_at);
      if (!rst_n) begin
        exp_q.delete();
        clr_q.delete();
      end
      case (rmode)
        1: out_ready = 1'($urandom);
        2: out_ready = (k >= 20);
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (k == 1) chk(busy && fb_read_enable && fb_read_addr == 0,
                      "busy_lat", {busy, fb_read_enable}, 3);
      if (out_valid && first_v < 0) first_v = k;
      if (rmode == 2 && k < 20 && fb_read_enable) begin
        if (rd_seen < 2) rd_a[rd_seen] = fb_read_addr;
        rd_seen++;
      end
      if (rmode == 2 && k == 19) begin
        chk(rd_seen == 2, "bp_reads", rd_seen, 2);
        chk(rd_a[0] == 0 && rd_a[1] == 1, "bp_addr", {rd_a[0], rd_a[1]}, 8'h01);
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        chk({busy, done, out_valid, fb_read_enable, fb_clear_write_enable,
             fb_read_addr, fb_clear_addr, out_data, out_last_x, out_last} == 0,
            "rst_out", {fb_read_addr, busy, out_valid, fb_read_enable}, 0);
        aborted = 1;
        break;
      end
      if (done) begin
        dones++;
        done_k = k;
        chk(!busy, "busy_at_done", busy, 0);
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    if (!aborted) begin
      chk(dones == 1, "done_count", dones, 1);
      chk(exp_q.size() == 0 && clr_q.size() == 0, "drained",
          exp_q.size(), 0);
      if (rmode == 0) begin
        chk(first_v == 2, "first_valid", first_v, 2);
        chk(done_k == N + 2, "done_lat", done_k, N + 2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_en = 1'b0;
    out_ready = 1'b1;
    for (int a = 0; a < N; a++) begin
      mem[a] = DW'(a);
      ref_mem[a] = DW'(a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({busy, done, out_valid, fb_read_enable, fb_clear_write_enable,
         out_data, out_last_x, out_last} == 0, "reset",
        {busy, done, out_valid, fb_read_enable}, 0);
    #1;
    rst_n = 1'b1;

    run_frame(0, 0, 0, 0);
    run_frame(1, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    for (int a = 0; a < N; a++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      mem[a] = v;
      ref_mem[a] = v;
    end
    run_frame(0, 1, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(0, 2, 0, 0);
    run_frame(0, 0, 1, 0);
    run_frame(0, 1, 0, 6);
    run_frame(0, 0, 0, 0);
    run_frame(1, 1, 0, 0);
    run_frame(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Framebuffer read side of the render pipeline: on a frame-start pulse it reads every framebuffer word in raster order through a dual-port framebuffer's read port. It delivers the words as a valid/ready pixel stream with end-of-line and end-of-frame markers toward the display path. It can optionally write a clear value back to each address after reading it, so the rasterizer starts the next frame on a cleared buffer.

## Interface
Parameters:
- FB_ADDR_WIDTH, 17: framebuffer address width; FB_WIDTH*FB_HEIGHT must be ≤ 2**FB_ADDR_WIDTH
- DATA_WIDTH, 4: framebuffer word width
- FB_WIDTH, 320: pixels per line, ≥ 1
- FB_HEIGHT, 240: lines per frame, ≥ 1
- CLEAR_VALUE, 0: word written back when clearing (DATA_WIDTH bits)

Ports:
- clk, input, 1: the single clock
- rst_n, input, 1: synchronous, active-low reset
- start, input, 1: single-cycle frame request; honoured only in IDLE
- clear_en, input, 1: sampled with an accepted start; enables clear-after-read for that frame
- busy, output, 1: high from the cycle after an accepted start until done
- done, output, 1: one-cycle pulse after the final pixel handshake
- fb_read_enable, output, 1: read request
- fb_read_addr, output, FB_ADDR_WIDTH: read address
- fb_read_data, input, DATA_WIDTH: read data, valid exactly 1 cycle after fb_read_enable
- fb_clear_write_enable, output, 1: clear write strobe
- fb_clear_addr, output, FB_ADDR_WIDTH: clear write address
- fb_clear_data, output, DATA_WIDTH: always CLEAR_VALUE
- out_data, output, DATA_WIDTH: pixel word
- out_valid, output, 1: out_data valid
- out_ready, input, 1: downstream accepts; a transfer occurs when out_valid && out_ready
- out_last_x, output, 1: current word is the last of its line
- out_last, output, 1: current word is the last of the frame

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: if start is high, latch clear_en, reset the read address/x/y counters to 0, and go to READ. Otherwise, stay.
- READ: issue one read per cycle while credits allow. Credits: buffered entries + reads in flight − pop this cycle < 2.
  - The address increments by 1 per issued read.
  - After address FB_WIDTH*FB_HEIGHT−1 is issued, go to DRAIN.
- DRAIN: issue no reads. When the word flagged out_last transfers, go to DONE.
- DONE: pulse done for one cycle, drop busy, and return to IDLE.
- Output buffer:
  - 2-entry skid buffer holding {data, last_x, last}, in FIFO order.
  - Returned read data is written into the buffer the cycle it arrives. Credit accounting guarantees it never overflows.
- Markers:
  - Tracked by x (0..FB_WIDTH−1) and y (0..FB_HEIGHT−1) counters that advance with each issued read.
  - last_x = (x == FB_WIDTH−1).
  - last = last_x && (y == FB_HEIGHT−1).
  - Markers travel with the data through the buffer.
- Clear: if latched clear_en is set, fb_clear_write_enable pulses in the cycle read data for address A returns, with fb_clear_addr = A. It never depends on out_ready.
- Arithmetic: address, x and y counters are unsigned. The address counter is FB_ADDR_WIDTH wide and never wraps within a frame.
- start asserted while busy is ignored and not queued.
- While out_valid is high and out_ready is low, out_data, out_last_x and out_last hold stable.

## Timing
- Reset (rst_n low at a clock edge) sets:
  - state = IDLE;
  - busy, done, out_valid, fb_read_enable and fb_clear_write_enable = 0;
  - fb_read_addr, fb_clear_addr, out_data, out_last_x and out_last = 0;
  - the buffer empty and no reads in flight.
- Reset mid-frame abandons the frame: from the next edge, no read or clear strobes and no out_valid. Data returning from a pre-reset read is discarded.
- Latency:
  - start at cycle 0 → busy = 1 and the first fb_read_enable (addr 0) at cycle 1.
  - out_valid for pixel 0 at cycle 2.
  - Clear write of addr 0 at cycle 2.
- Throughput: with out_ready held high, one pixel transfers per cycle. For N = FB_WIDTH*FB_HEIGHT, the last transfer is at cycle N+1 and done = 1 at cycle N+2 with busy = 0 the same cycle. The next start is accepted at cycle N+3.
- Backpressure: with out_ready low, at most 2 words are outstanding and fb_read_enable stays low until a pop frees a credit. A pop and an arrival in the same cycle are both handled.
- A 1×1 frame is valid: the single word has out_last_x = out_last = 1.

## Test plan
- 4×3 frame, out_ready = 1, clear_en = 0, memory preloaded with addr value → out_data 0..11 on cycles 2..13; out_last_x on words 3, 7 and 11; out_last only on 11; done at cycle 14; no clear strobes.
- Same frame with clear_en = 1 → 12 clear writes, addresses 0..11 on cycles 2..13, each with data CLEAR_VALUE; a second frame then reads all CLEAR_VALUE.
- out_ready toggled with a pseudorandom pattern → output sequence identical to the first scenario; no read issued while 2 words are outstanding; data holds stable while stalled.
- out_ready low for 20 cycles at start → exactly 2 reads issued (addr 0, 1); stream resumes in order once ready rises.
- start pulsed again at cycles 5 and 10 of a frame → ignored; exactly one done.
- rst_n low for one cycle mid-frame → all outputs 0 next cycle; a new start produces a full, correct frame from addr 0.
